// File: rtl/cpu_pkg.sv
// Shared definitions for the ARM-subset front end: field positions,
// PC arithmetic constants and the fetch FSM state type.
package cpu_pkg;

    localparam int COND_MSB  = 31;
    localparam int COND_LSB  = 28;
    localparam int OP_MSB    = 27;
    localparam int OP_LSB    = 26;
    localparam int FUNCT_MSB = 25;
    localparam int FUNCT_LSB = 20;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 12;
    localparam int SH_MSB    = 6;
    localparam int SH_LSB    = 5;

    localparam int PC_STEP       = 4;
    localparam int PC_R15_OFFSET = 8;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE,
        ERR
    } fetch_state_t;

endpackage

// File: rtl/pc_register.sv
// Program counter: reset / hold / sequential step / word-aligned branch.
// Ports: clk, rst (sync, active-high), load_en, sel_branch,
//        branch_target[ADDR_W], pc[ADDR_W].
module pc_register
    import cpu_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic              sel_branch,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_en) begin
            if (sel_branch) begin
                // targets are forced onto a word boundary
                pc_d = branch_target & ~ADDR_W'(3);
            end else begin
                pc_d = pc_q + ADDR_W'(PC_STEP);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, fetches over imem req/ack, issues the
// word and its decoded fields to control_unit, accepts pc_src redirects.
// Ports: clk, rst (sync, active-high), pc_src, branch_target, stall,
//        imem_req/addr/ack/rdata, instr_valid, instr, cond, op, funct,
//        rd, sh, pc, pc_plus8, fetch_err.
// Optional: INSTR_FETCH_PERF_CNT_EN adds fetch_count and redirect_count.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_src,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [3:0]        cond,
    output logic [1:0]        op,
    output logic [5:0]        funct,
    output logic [3:0]        rd,
    output logic [1:0]        sh,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus8,
    output logic              fetch_err
`ifdef INSTR_FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_count,
    output logic [15:0]       redirect_count
`endif
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    fetch_state_t     state_q;
    fetch_state_t     state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [31:0]      instr_q;
    logic [31:0]      instr_d;
    logic             err_q;
    logic             err_d;
    logic             pc_load;
    logic             pc_branch;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        instr_d   = instr_q;
        err_d     = err_q;
        pc_load   = 1'b0;
        pc_branch = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end
                end
            end
            ISSUE: begin
                // stall freezes everything, including the redirect
                if (!stall) begin
                    pc_load   = 1'b1;
                    pc_branch = pc_src;
                    state_d   = FETCH;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            instr_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            err_q   <= err_d;
        end
    end

    pc_register #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(RESET_PC)
    ) u_pc (
        .clk          (clk),
        .rst          (rst),
        .load_en      (pc_load),
        .sel_branch   (pc_branch),
        .branch_target(branch_target),
        .pc           (pc)
    );

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = imem_req ? pc : '0;
    assign instr_valid = (state_q == ISSUE);
    assign fetch_err   = err_q;
    assign pc_plus8    = pc + ADDR_W'(PC_R15_OFFSET);

    assign instr = instr_q;
    assign cond  = instr_q[COND_MSB:COND_LSB];
    assign op    = instr_q[OP_MSB:OP_LSB];
    assign funct = instr_q[FUNCT_MSB:FUNCT_LSB];
    assign rd    = instr_q[RD_MSB:RD_LSB];
    assign sh    = instr_q[SH_MSB:SH_LSB];

`ifdef INSTR_FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] fetch_cnt_d;
    logic [15:0] redir_cnt_q;
    logic [15:0] redir_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        redir_cnt_d = redir_cnt_q;
        if (pc_load) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
            if (pc_branch && redir_cnt_q != 16'hFFFF) begin
                redir_cnt_d = redir_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign fetch_count    = fetch_cnt_q;
    assign redirect_count = redir_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_instr_fetch_unit;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_src = 1'b0;
    logic [31:0] branch_target = '0;
    logic        stall = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        instr_valid;
    logic [31:0] instr;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic [1:0]  sh;
    logic [31:0] pc;
    logic [31:0] pc_plus8;
    logic        fetch_err;
`ifdef INSTR_FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [15:0] redirect_count;
`endif

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .pc_src       (pc_src),
        .branch_target(branch_target),
        .stall        (stall),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .cond         (cond),
        .op           (op),
        .funct        (funct),
        .rd           (rd),
        .sh           (sh),
        .pc           (pc),
        .pc_plus8     (pc_plus8),
        .fetch_err    (fetch_err)
`ifdef INSTR_FETCH_PERF_CNT_EN
        ,
        .fetch_count   (fetch_count),
        .redirect_count(redirect_count)
`endif
    );

    int n_pass = 0;
    int n_tot  = 0;

    function automatic void chk(string name, logic [63:0] act,
                                logic [63:0] exp);
        n_tot++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%h expected=%h t=%0t",
                     name, act, exp, $time);
        end
    endfunction

    // Behavioural model: which phase the unit is in, the PC and the word held.
    bit          m_live  = 1'b0;
    bit          m_idle  = 1'b0;
    bit          m_fetch = 1'b0;
    bit          m_issue = 1'b0;
    bit          m_err   = 1'b0;
    int          m_wait  = 0;
    logic [31:0] m_pc    = '0;
    logic [31:0] m_instr = '0;
    logic [31:0] m_fc    = '0;
    logic [15:0] m_rc    = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_live  <= 1'b1;
            m_idle  <= 1'b1;
            m_fetch <= 1'b0;
            m_issue <= 1'b0;
            m_err   <= 1'b0;
            m_wait  <= 0;
            m_pc    <= 32'h0;
            m_instr <= 32'h0;
            m_fc    <= '0;
            m_rc    <= '0;
        end else if (m_idle) begin
            m_idle  <= 1'b0;
            m_fetch <= 1'b1;
        end else if (m_fetch) begin
            if (imem_ack) begin
                m_instr <= imem_rdata;
                m_fetch <= 1'b0;
                m_issue <= 1'b1;
                m_wait  <= 0;
            end else if (m_wait + 1 == TO) begin
                m_err   <= 1'b1;
                m_fetch <= 1'b0;
            end else begin
                m_wait <= m_wait + 1;
            end
        end else if (m_issue && !stall) begin
            m_pc    <= pc_src ? (branch_target & 32'hFFFF_FFFC)
                              : m_pc + 32'd4;
            m_issue <= 1'b0;
            m_fetch <= 1'b1;
            m_fc    <= m_fc + 32'd1;
            if (pc_src && m_rc != 16'hFFFF) m_rc <= m_rc + 16'd1;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("handshake",
                64'({imem_req, instr_valid, fetch_err, imem_addr}),
                64'({m_fetch, m_issue, m_err,
                     (m_fetch ? m_pc : 32'h0)}));
            chk("instr", 64'(instr), 64'(m_instr));
            chk("fields", 64'({cond, op, funct, rd, sh}),
                64'({4'(m_instr >> 28), 2'(m_instr >> 26),
                     6'(m_instr >> 20), 4'(m_instr >> 12),
                     2'(m_instr >> 5)}));
            chk("pc", {pc, pc_plus8}, {m_pc, m_pc + 32'd8});
`ifdef INSTR_FETCH_PERF_CNT_EN
            chk("perf", 64'({fetch_count, redirect_count}),
                64'({m_fc, m_rc}));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_req();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (imem_req) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) chk("req_timeout", 64'(imem_req), 64'(1));
    endtask

    task automatic fetch_word(input logic [31:0] data, input int dly,
                              input logic [31:0] exp_addr);
        wait_req();
        repeat (dly) step();
        chk("fetch_addr", 64'(imem_addr), 64'(exp_addr));
        imem_ack   = 1'b1;
        imem_rdata = data;
        step();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
    endtask

    int ackp;

    initial begin
        // reset state
        repeat (3) step();
        chk("rst_valid", 64'(instr_valid), 64'(0));
        chk("rst_req", 64'(imem_req), 64'(0));
        chk("rst_instr", 64'(instr), 64'(0));
        chk("rst_pc", 64'(pc), 64'(0));
        rst = 1'b0;

        // first fetch, ack two cycles after the request
        fetch_word(32'hE281_3004, 2, 32'h0);
        chk("t1_valid", 64'(instr_valid), 64'(1));
        chk("t1_fields", 64'({cond, op, funct, rd, sh}),
            64'({4'hE, 2'd0, 6'h28, 4'd3, 2'd0}));
        chk("t1_pc", {pc, pc_plus8}, {32'h0, 32'h8});

        // sequential fetch
        for (int k = 1; k < 3; k++) begin
            fetch_word($urandom, 0, 32'(k * 4));
            chk("seq_pc", 64'(pc), 64'(k * 4));
        end

        // stall holds the issue and ignores pc_src
        stall         = 1'b1;
        pc_src        = 1'b1;
        branch_target = 32'h55;
        repeat (3) step();
        chk("stall_hold", 64'({instr_valid, pc}), 64'({1'b1, 32'h8}));
        stall         = 1'b0;
        branch_target = 32'h103;
        step();
        pc_src = 1'b0;
        fetch_word($urandom, 1, 32'h100);
        chk("redir_pc", 64'(pc), 64'(32'h100));

        // wrap of PC arithmetic
        pc_src        = 1'b1;
        branch_target = 32'hFFFF_FFFF;
        step();
        pc_src = 1'b0;
        fetch_word($urandom, 0, 32'hFFFF_FFFC);
        chk("wrap_p8", 64'(pc_plus8), 64'(32'h4));
        fetch_word($urandom, 0, 32'h0);

        // timeout
        wait_req();
        repeat (TO - 1) step();
        chk("to_early", 64'(fetch_err), 64'(0));
        step();
        chk("to_err", 64'({fetch_err, imem_req}), 64'({1'b1, 1'b0}));
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        repeat (3) step();
        imem_ack = 1'b0;
        chk("to_ack_ignored", 64'(instr_valid), 64'(0));
        rst = 1'b1;
        step();
        chk("to_clear", 64'(fetch_err), 64'(0));
        rst = 1'b0;
        step();
        chk("to_restart", 64'({imem_req, imem_addr}), 64'({1'b1, 32'h0}));

        // reset mid-fetch with a same-cycle ack
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        step();
        imem_ack = 1'b0;
        chk("midrst", 64'({instr, instr_valid, imem_req}), 64'(0));
        rst = 1'b0;
        chk("midrst_idle", 64'(imem_req), 64'(0));
        step();
        chk("midrst_fetch", 64'({imem_req, imem_addr}),
            64'({1'b1, 32'h0}));

        // randomized traffic
        ackp = 60;
        for (int i = 0; i < 3000; i++) begin
            if (i % 300 == 0) ackp = (ackp == 60) ? 4 : 60;
            rst           = ($urandom_range(0, 249) == 0);
            imem_ack      = ($urandom_range(0, 99) < ackp);
            imem_rdata    = $urandom;
            stall         = ($urandom_range(0, 2) == 0);
            pc_src        = ($urandom_range(0, 3) == 0);
            branch_target = $urandom;
            step();
        end
        rst      = 1'b0;
        imem_ack = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
